ks_adder_pipe: RTL
==================

// Module: ks_adder_pipe
// PURPOSE
//   Parametrised, pipelined Kogge-Stone adder/subtractor; next generation of the 16-bit
//   combinational prefix adder used by the booth multiplier datapath. One register rank
//   per prefix level, valid/ready handshake with full backpressure, one op per cycle.
//   Adds subtract mode, signed-overflow flag and WIDTH generalisation.
// PARAMETERS
//   WIDTH   16   operand/sum width; any power of two, 4..64
//   LEVELS  $clog2(WIDTH)  prefix levels; derived localparam, not overridable
// PORTS
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block can accept operands this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry in; ignored when sub=1
//   sub        in   1      0: a+b+cin   1: a-b (a + ~b + 1)
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  result
//   cout       out  1      carry out (sub=1: 1 means no borrow, a>=b unsigned)
//   ovf        out  1      signed two's-complement overflow
// BEHAVIOUR
//   - Reset: all stage valid bits 0; out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 the
//     cycle after rst deasserts. rst mid-operation drops every in-flight op, no output.
//   - Pipeline: stage 0 = pre-process (b_eff = sub ? ~b : b, c0 = sub ? 1 : cin,
//     G=a&b_eff, P=a^b_eff, registered); stages 1..LEVELS = one KS prefix level each,
//     span 2^(k-1), grey cell where span reaches c0, black cell elsewhere; final stage =
//     sum = P ^ carry, cout, ovf registered. Latency = LEVELS+2 cycles (WIDTH=16: 6).
//   - ovf = carry into MSB XOR carry out of MSB.
//   - Handshake: advance = !out_valid | out_ready. in_ready = advance (combinational).
//     On advance every stage shifts one rank; op accepted when in_valid & in_ready.
//     On !advance every stage holds (data and valid), sum/cout/ovf stable while
//     out_valid & !out_ready.
//   - Bubbles propagate as valid=0 ranks; they are not squeezed out (fixed latency).
//   - Simultaneous accept and output transfer in same cycle: both occur; sustained
//     throughput 1 op/cycle with in_valid=out_ready=1.
//   - a, b, cin, sub sampled only on accept; changes while in_ready=0 are ignored.
//   - Bubble stages may keep stale data; only valid-qualified outputs are meaningful.
//   - No internal FSM beyond per-stage valid bits; no overflow/underflow conditions exist
//     since the pipeline never accepts without a free slot.
// TESTING (WIDTH=16)
//   1 rst 3 cycles, then a=16'h1234,b=16'h4321,cin=0,sub=0 -> 6 cycles later
//     out_valid=1, sum=16'h5555, cout=0, ovf=0; out_valid=0 during reset.
//   2 a=16'hFFFF,b=16'h0001,cin=1,sub=0 -> sum=16'h0001, cout=1, ovf=0;
//     a=16'h7FFF,b=16'h0001,cin=0 -> sum=16'h8000, cout=0, ovf=1.
//   3 sub=1: a=16'h0005,b=16'h0007,cin=1 -> sum=16'hFFFE, cout=0, ovf=0 (cin ignored);
//     a=16'h8000,b=16'h0001 -> sum=16'h7FFF, cout=1, ovf=1.
//   4 stream 20 back-to-back ops, out_ready=1 -> 20 results on consecutive cycles,
//     in order, first at cycle 6, in_ready never deasserts.
//   5 fill pipe, hold out_ready=0 for 10 cycles -> in_ready=0, outputs frozen,
//     no loss/dup; release -> remaining ops drain in order.
//   6 rst asserted with 4 ops in flight -> no out_valid after reset; next op after reset
//     returns correct result at latency 6. Random 10k ops vs a+b model, all modes.

Source files
------------

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor: one register rank per prefix level,
// fixed latency LEVELS+2, valid/ready handshake with full-pipeline stall.
module ks_adder_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LEVELS = $clog2(WIDTH);

  logic             w_adv;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;
  logic [WIDTH-1:0] w_p0;
  logic [WIDTH-1:0] w_g0;

  logic [WIDTH-1:0] r_g_p   [0:LEVELS];
  logic [WIDTH-1:0] r_pg_p  [0:LEVELS-1];
  logic [WIDTH-1:0] r_p_p   [0:LEVELS];
  logic             r_c0_p  [0:LEVELS];
  logic             r_vld_p [0:LEVELS];

  logic [WIDTH-1:0] w_g_nxt  [1:LEVELS];
  logic [WIDTH-1:0] w_pg_nxt [1:LEVELS-1];

  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_vld;

  assign w_adv    = !r_out_vld || out_ready;
  assign in_ready = w_adv;

  // Stage 0: operand conditioning; carry-in folded into bit 0 generate
  always_comb begin
    w_b_eff = sub ? ~b : b;
    w_c0    = sub | cin;
    w_p0    = a ^ w_b_eff;
    w_g0    = a & w_b_eff;
    w_g0[0] = (a[0] & w_b_eff[0]) | (w_p0[0] & w_c0);
  end

  // Stages 1..LEVELS: one Kogge-Stone prefix level each; bits below the span
  // already hold their complete prefix and pass through unchanged
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int SPAN = 1 << (k - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= SPAN) begin : g_black
        assign w_g_nxt[k][i] = r_g_p[k-1][i] | (r_pg_p[k-1][i] & r_g_p[k-1][i-SPAN]);
        if (k < LEVELS) begin : g_pg
          assign w_pg_nxt[k][i] = r_pg_p[k-1][i] & r_pg_p[k-1][i-SPAN];
        end
      end else begin : g_pass
        assign w_g_nxt[k][i] = r_g_p[k-1][i];
        if (k < LEVELS) begin : g_pg
          assign w_pg_nxt[k][i] = r_pg_p[k-1][i];
        end
      end
    end
  end

  // Final stage: carry into bit i is the prefix generate of bits i-1..0
  always_comb begin
    w_carry = {r_g_p[LEVELS][WIDTH-2:0], r_c0_p[LEVELS]};
    w_sum   = r_p_p[LEVELS] ^ w_carry;
    w_cout  = r_g_p[LEVELS][WIDTH-1];
    w_ovf   = w_carry[WIDTH-1] ^ w_cout;
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_g_p[0]  <= w_g0;
      r_pg_p[0] <= w_p0;
      r_p_p[0]  <= w_p0;
      r_c0_p[0] <= w_c0;
      for (int k = 1; k <= LEVELS; k++) begin
        r_g_p[k]  <= w_g_nxt[k];
        r_p_p[k]  <= r_p_p[k-1];
        r_c0_p[k] <= r_c0_p[k-1];
      end
      for (int k = 1; k < LEVELS; k++) begin
        r_pg_p[k] <= w_pg_nxt[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= LEVELS; k++) begin
        r_vld_p[k] <= 1'b0;
      end
      r_out_vld <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_adv) begin
      r_vld_p[0] <= in_valid;
      for (int k = 1; k <= LEVELS; k++) begin
        r_vld_p[k] <= r_vld_p[k-1];
      end
      r_out_vld <= r_vld_p[LEVELS];
      r_sum     <= w_sum;
      r_cout    <= w_cout;
      r_ovf     <= w_ovf;
    end
  end

  assign out_valid = r_out_vld;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
